// File: rtl/activation_skew_buffer_if.sv
// Activation skew buffer bus interface.
//
// Groups the vector handshake and output lanes of activation_skew_buffer.
//   in_valid   in_data holds a valid vector
//   in_ready   buffer accepts in_data this cycle
//   in_data    N*W bits, row k at [k*W +: W]
//   out_data   N*W bits, row k at [k*W +: W]
//   out_valid  N bits, per-row valid
// master: the producer/consumer side (SRAM read port + array edge).
// slave:  the buffer itself.
interface activation_skew_buffer_if #(
  parameter int unsigned SYSTOLIC_SIZE    = 8,
  parameter int unsigned ACTIVATION_WIDTH = 8
);
  logic                                         in_valid;
  logic                                         in_ready;
  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]    in_data;
  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]    out_data;
  logic [SYSTOLIC_SIZE-1:0]                     out_valid;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/activation_skew_buffer.sv
// Activation skew buffer.
//
// Sits between the activation SRAM read port and the west edge of the systolic
// array. Each row k owns an (N-1)-stage delay line of {valid, data}; the output
// tap for row k is chosen by the latched mode:
//   skew   (00): tap k        (45 degree skew)
//   parallel(01/11): tap 0    (combinational pass-through)
//   deskew (10): tap N-1-k    (mirror, used on the partial-sum side)
// Tap 0 is taken straight from the input; tap d>0 is stage d-1.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   mode         requested mode, latched only while the lines are empty and idle
//   stall        freezes every delay stage and masks all out_valid bits
//   flush        single-cycle request to drain the delay lines (IDLE only)
//   busy         some delay stage holds a valid entry
//   flush_done   one-cycle pulse when a flush has drained the lines
//   bus          in_valid/in_ready/in_data and out_data/out_valid lanes
module activation_skew_buffer #(
  parameter int unsigned SYSTOLIC_SIZE    = 8,
  parameter int unsigned ACTIVATION_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    busy,
  output logic                    flush_done,
  activation_skew_buffer_if.slave bus
);

  localparam int unsigned N      = SYSTOLIC_SIZE;
  localparam int unsigned W      = ACTIVATION_WIDTH;
  localparam int unsigned Stages = N - 1;

  localparam logic [1:0] ModeSkew   = 2'b00;
  localparam logic [1:0] ModePar    = 2'b01;
  localparam logic [1:0] ModeDeskew = 2'b10;
  localparam logic [1:0] ModeRsvd   = 2'b11;

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StFlush = 2'b01;
  localparam logic [1:0] StDone  = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [W-1:0]      data_q  [N][Stages];
  logic [Stages-1:0] valid_q [N];

  logic              in_ready;
  logic              accept;
  logic [W-1:0]      in_row    [N];
  logic [N-1:0]      row_busy;
  logic [N*W-1:0]    out_data_c;
  logic [N-1:0]      out_valid_c;

  // ---------------------------------------------------------------------------
  // Handshake and status
  // ---------------------------------------------------------------------------
  assign in_ready   = (state_q == StIdle) & ~stall;
  assign accept     = bus.in_valid & in_ready;
  assign flush_done = (state_q == StDone);

  // busy looks at every stage, including ones past the active tap, so a flush
  // or mode change never leaves stale valid entries behind.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      row_busy[k] = |valid_q[k];
    end
  end
  assign busy = |row_busy;

  // ---------------------------------------------------------------------------
  // Delay lines
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        valid_q[k] <= '0;
        for (int unsigned j = 0; j < Stages; j++) begin
          data_q[k][j] <= '0;
        end
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < N; k++) begin
        // A cycle with no accepted vector pushes a zero bubble.
        valid_q[k][0] <= accept;
        data_q[k][0]  <= accept ? in_row[k] : '0;
        for (int unsigned j = 1; j < Stages; j++) begin
          valid_q[k][j] <= valid_q[k][j-1];
          data_q[k][j]  <= data_q[k][j-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode latch: only retargets taps when nothing is in flight, so a stream is
  // never split across two tap patterns.
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d = mode_q;
    if (!busy && !accept) begin
      mode_d = (mode == ModeRsvd) ? ModePar : mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (flush) state_d = StFlush;
      StFlush: if (!busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeSkew;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-row tap selection
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_row
    localparam int unsigned SkewTap   = k;
    localparam int unsigned DeskewTap = N - 1 - k;

    int unsigned  tap;
    logic [W-1:0] row_data;
    logic         row_valid;

    assign in_row[k] = bus.in_data[k*W +: W];

    always_comb begin
      case (mode_q)
        ModeSkew:   tap = SkewTap;
        ModeDeskew: tap = DeskewTap;
        default:    tap = 0;
      endcase
    end

    // Tap 0 is combinational; under stall accept is 0 so it shows zero.
    // Deeper taps keep showing the held stage during stall, but never valid.
    always_comb begin
      row_data  = accept ? in_row[k] : '0;
      row_valid = accept;
      for (int unsigned j = 0; j < Stages; j++) begin
        if (tap == j + 1) begin
          row_data  = data_q[k][j];
          row_valid = valid_q[k][j] & ~stall;
        end
      end
    end

    assign out_data_c[k*W +: W] = row_data;
    assign out_valid_c[k]       = row_valid;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_c;
  assign bus.out_valid = out_valid_c;

endmodule

// File: tb/tb_activation_skew_buffer.sv
module tb_activation_skew_buffer;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic       flush_done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  activation_skew_buffer_if #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(W)) bus ();

  activation_skew_buffer #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .stall      (stall),
    .flush      (flush),
    .busy       (busy),
    .flush_done (flush_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] vec(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] v, input logic [31:0] d);
    chk({tag, ".valid"}, {28'd0, bus.out_valid}, {28'd0, v});
    chk({tag, ".data"}, bus.out_data, d);
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
  task automatic cyc(input logic v, input logic [31:0] d, input logic s, input logic f,
                     input logic [1:0] m);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    stall        = s;
    flush        = f;
    mode         = m;
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk_out("rst", 4'b0000, 32'h0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.flush_done", flush_done, 1'b0);
    chk1("rst.in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    // Skew ramp
    cyc(1'b1, vec(8'h10), 1'b0, 1'b0, 2'b00);
    chk_out("skew0", 4'b0001, 32'h00000010);
    chk1("skew0.in_ready", bus.in_ready, 1'b1);
    cyc(1'b1, vec(8'h20), 1'b0, 1'b0, 2'b00);
    chk_out("skew1", 4'b0011, 32'h00001120);
    chk1("skew1.busy", busy, 1'b1);
    cyc(1'b1, vec(8'h30), 1'b0, 1'b0, 2'b00);
    chk_out("skew2", 4'b0111, 32'h00122130);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("skew3", 4'b1110, 32'h13223100);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("skew4", 4'b1100, 32'h23320000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("skew5", 4'b1000, 32'h33000000);
    chk1("skew5.busy", busy, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk_out("skew6", 4'b0000, 32'h0);
    chk1("skew6.busy", busy, 1'b0);

    // Parallel
    cyc(1'b1, vec(8'hA0), 1'b0, 1'b0, 2'b01);
    chk_out("par0", 4'b1111, 32'hA3A2A1A0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    chk_out("par1", 4'b0000, 32'h0);
    chk1("par1.busy", busy, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    chk1("par3.busy", busy, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    chk1("par4.busy", busy, 1'b0);

    // Deskew
    cyc(1'b1, vec(8'hA0), 1'b0, 1'b0, 2'b10);
    chk_out("desk0", 4'b1000, 32'hA3000000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    chk_out("desk1", 4'b0100, 32'h00A20000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    chk_out("desk2", 4'b0010, 32'h0000A100);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
    chk_out("desk3", 4'b0001, 32'h000000A0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("desk4.busy", busy, 1'b0);

    // Stall mid-burst
    cyc(1'b1, vec(8'h40), 1'b0, 1'b0, 2'b00);
    chk_out("stall0", 4'b0001, 32'h00000040);
    cyc(1'b1, vec(8'h50), 1'b0, 1'b0, 2'b00);
    chk_out("stall1", 4'b0011, 32'h00004150);
    cyc(1'b1, vec(8'h60), 1'b1, 1'b0, 2'b00);
    chk_out("stall2", 4'b0000, 32'h00425100);
    chk1("stall2.in_ready", bus.in_ready, 1'b0);
    cyc(1'b1, vec(8'h60), 1'b1, 1'b0, 2'b00);
    chk_out("stall3", 4'b0000, 32'h00425100);
    chk1("stall3.in_ready", bus.in_ready, 1'b0);
    cyc(1'b1, vec(8'h60), 1'b0, 1'b0, 2'b00);
    chk_out("stall4", 4'b0111, 32'h00425160);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("stall5", 4'b1110, 32'h43526100);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("stall6", 4'b1100, 32'h53620000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("stall7", 4'b1000, 32'h63000000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("stall8.busy", busy, 1'b0);

    // Mode guard: request parallel while skewed data is in flight
    cyc(1'b1, vec(8'hB0), 1'b0, 1'b0, 2'b00);
    chk_out("guard0", 4'b0001, 32'h000000B0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk_out("guard1", 4'b0010, 32'h0000B100);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk_out("guard2", 4'b0100, 32'h00B20000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk_out("guard3", 4'b1000, 32'hB3000000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk1("guard4.busy", busy, 1'b0);
    cyc(1'b1, vec(8'hC0), 1'b0, 1'b0, 2'b01);
    chk_out("guard5", 4'b1111, 32'hC3C2C1C0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("guard6", 4'b0000, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("guard9.busy", busy, 1'b0);

    // Flush from a filled pipeline, flush alongside a 4th vector
    cyc(1'b1, vec(8'h10), 1'b0, 1'b0, 2'b00);
    chk_out("fl0", 4'b0001, 32'h00000010);
    cyc(1'b1, vec(8'h20), 1'b0, 1'b0, 2'b00);
    cyc(1'b1, vec(8'h30), 1'b0, 1'b0, 2'b00);
    cyc(1'b1, vec(8'h40), 1'b0, 1'b1, 2'b00);
    chk1("fl3.in_ready", bus.in_ready, 1'b1);
    chk_out("fl3", 4'b1111, 32'h13223140);
    cyc(1'b1, vec(8'h50), 1'b0, 1'b0, 2'b00);
    chk1("fl4.in_ready", bus.in_ready, 1'b0);
    chk_out("fl4", 4'b1110, 32'h23324100);
    chk1("fl4.flush_done", flush_done, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("fl5.in_ready", bus.in_ready, 1'b0);
    chk_out("fl5", 4'b1100, 32'h33420000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("fl6", 4'b1000, 32'h43000000);
    chk1("fl6.busy", busy, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("fl7.busy", busy, 1'b0);
    chk1("fl7.flush_done", flush_done, 1'b0);
    chk1("fl7.in_ready", bus.in_ready, 1'b0);
    cyc(1'b1, vec(8'h50), 1'b0, 1'b0, 2'b00);
    chk1("fl8.flush_done", flush_done, 1'b1);
    chk1("fl8.in_ready", bus.in_ready, 1'b0);
    chk_out("fl8", 4'b0000, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("fl9.flush_done", flush_done, 1'b0);
    chk1("fl9.in_ready", bus.in_ready, 1'b1);

    // Flush while empty; mode 01 gets latched along the way
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
    chk1("fe0.flush_done", flush_done, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk1("fe1.flush_done", flush_done, 1'b0);
    chk1("fe1.in_ready", bus.in_ready, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
    chk1("fe2.flush_done", flush_done, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk1("fe3.flush_done", flush_done, 1'b0);
    chk1("fe3.in_ready", bus.in_ready, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk1("fe4.flush_done", flush_done, 1'b0);

    // Reset mid-flush
    cyc(1'b1, vec(8'h10), 1'b0, 1'b1, 2'b01);
    chk_out("rf0", 4'b1111, 32'h13121110);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
    chk1("rf1.busy", busy, 1'b1);
    chk1("rf1.in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rf_rst.busy", busy, 1'b0);
    chk_out("rf_rst", 4'b0000, 32'h0);
    chk1("rf_rst.flush_done", flush_done, 1'b0);
    chk1("rf_rst.in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = vec(8'hD0);
    #1;
    // mode input is still 01, but mode_r restarted at 00 so this is skewed.
    chk1("rf2.in_ready", bus.in_ready, 1'b1);
    chk1("rf2.flush_done", flush_done, 1'b0);
    chk_out("rf2", 4'b0001, 32'h000000D0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("rf3", 4'b0010, 32'h0000D100);
    chk1("rf3.flush_done", flush_done, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("rf4", 4'b0100, 32'h00D20000);
    chk1("rf4.flush_done", flush_done, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk_out("rf5", 4'b1000, 32'hD3000000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    chk1("rf6.busy", busy, 1'b0);
    chk1("rf6.flush_done", flush_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
